// File: rtl/mon_pkg.sv
// ============================================================================
//  Module   : mon_pkg
//  Purpose  : Shared constants, state encoding and header helper for the
//             monitor-protocol host initiator (mon_host).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mon_pkg;

    // Command op codes carried in header byte 0
    localparam logic [1:0] OP_FLUSH = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_DUMP  = 2'd2;
    localparam logic [1:0] OP_EXEC  = 2'd3;

    // Error codes reported on err_code alongside the err pulse
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ECHO    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    // Header geometry: six bytes, index 0..5
    localparam int         HDR_LEN  = 6;
    localparam logic [2:0] HDR_LAST = 3'(HDR_LEN - 1);

    // 100 ms at 12 MHz
    localparam logic [23:0] DEFAULT_TIMEOUT = 24'd1200000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR_TX    = 3'd1,
        ST_HDR_ECHO  = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_LOAD_TX   = 3'd4,
        ST_LOAD_ECHO = 3'd5,
        ST_DUMP_RX   = 3'd6,
        ST_FINISH    = 3'd7
    } state_e;

    // Header byte selected by index: {op, 0x00, addr hi, addr lo, len hi, len lo}
    function automatic logic [7:0] hdr_byte(
        input logic [1:0]  op,
        input logic [15:0] addr,
        input logic [15:0] len,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = {6'd0, op};
            3'd1:    b = 8'h00;
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            3'd4:    b = len[15:8];
            default: b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mon_host.sv
// ============================================================================
//  Module   : mon_host
//  Purpose  : Host-side initiator of the monitor serial protocol. Sends a
//             6-byte header then load payload or receives dump payload, using
//             stop-and-wait transmission checked against the UART echo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_host
    import mon_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,

    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,

    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,

    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,

    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,

    input  logic        rx_strobe,
    input  logic [7:0]  rx_data
);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] len_q;
    logic [2:0]  hdr_idx_q;
    logic [7:0]  wr_byte_q;
    logic [23:0] tmo_q;
    logic [7:0]  tx_byte_q;
    logic        tx_start_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        done_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic        fault;
    logic [1:0]  fault_code;
    logic        in_wait;

    // States in which the timeout counter runs
    assign in_wait = (state_q == ST_HDR_ECHO) || (state_q == ST_LOAD_ECHO) ||
                     (state_q == ST_DUMP_RX);

    // Error detection: unexpected/mismatched echo, silent line, dump overrun
    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_NONE;
        case (state_q)
            ST_HDR_TX, ST_LOAD_TX: begin
                // Nothing should arrive before our byte has been launched
                if (rx_strobe) begin
                    fault      = 1'b1;
                    fault_code = ERR_ECHO;
                end
            end
            ST_HDR_ECHO, ST_LOAD_ECHO: begin
                if (rx_strobe) begin
                    if (rx_data != tx_byte_q) begin
                        fault      = 1'b1;
                        fault_code = ERR_ECHO;
                    end
                end else if (tmo_q == 24'd0) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                end
            end
            ST_DUMP_RX: begin
                if (rx_strobe) begin
                    // Holding register still full and not being drained now
                    if (rd_valid_q && !rd_ready) begin
                        fault      = 1'b1;
                        fault_code = ERR_OVERRUN;
                    end
                end else if (tmo_q == 24'd0) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Protocol sequencer with registered strobes and data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_FLUSH;
            addr_q     <= 16'd0;
            len_q      <= 16'd0;
            hdr_idx_q  <= 3'd0;
            wr_byte_q  <= 8'd0;
            tmo_q      <= 24'd0;
            tx_byte_q  <= 8'd0;
            tx_start_q <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            if (rd_valid_q && rd_ready) begin
                rd_valid_q <= 1'b0;
            end

            // Wait counter: count down while waiting, reload on any received byte
            if (in_wait) begin
                if (rx_strobe) begin
                    tmo_q <= TIMEOUT;
                end else if (tmo_q != 24'd0) begin
                    tmo_q <= tmo_q - 24'd1;
                end
            end

            if (fault) begin
                err_q      <= 1'b1;
                err_code_q <= fault_code;
                rd_valid_q <= 1'b0;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            op_q      <= cmd_op;
                            addr_q    <= cmd_addr;
                            len_q     <= cmd_len;
                            hdr_idx_q <= 3'd0;
                            state_q   <= ST_HDR_TX;
                        end
                    end
                    ST_HDR_TX: begin
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            tx_byte_q  <= hdr_byte(op_q, addr_q, len_q, hdr_idx_q);
                            tmo_q      <= TIMEOUT;
                            state_q    <= ST_HDR_ECHO;
                        end
                    end
                    ST_HDR_ECHO: begin
                        // Echo already verified by the fault logic when rx_strobe is set
                        if (rx_strobe) begin
                            if (hdr_idx_q != HDR_LAST) begin
                                hdr_idx_q <= hdr_idx_q + 3'd1;
                                state_q   <= ST_HDR_TX;
                            end else if (op_q == OP_LOAD && len_q != 16'd0) begin
                                state_q <= ST_LOAD_WAIT;
                            end else if (op_q == OP_DUMP && len_q != 16'd0) begin
                                tmo_q   <= TIMEOUT;
                                state_q <= ST_DUMP_RX;
                            end else begin
                                state_q <= ST_FINISH;
                            end
                        end
                    end
                    ST_LOAD_WAIT: begin
                        if (wr_valid) begin
                            wr_byte_q <= wr_data;
                            state_q   <= ST_LOAD_TX;
                        end
                    end
                    ST_LOAD_TX: begin
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            tx_byte_q  <= wr_byte_q;
                            tmo_q      <= TIMEOUT;
                            state_q    <= ST_LOAD_ECHO;
                        end
                    end
                    ST_LOAD_ECHO: begin
                        if (rx_strobe) begin
                            len_q   <= len_q - 16'd1;
                            state_q <= (len_q == 16'd1) ? ST_FINISH : ST_LOAD_WAIT;
                        end
                    end
                    ST_DUMP_RX: begin
                        if (rx_strobe) begin
                            rd_data_q  <= rx_data;
                            rd_valid_q <= 1'b1;
                            len_q      <= len_q - 16'd1;
                            if (len_q == 16'd1) begin
                                state_q <= ST_FINISH;
                            end
                        end
                    end
                    ST_FINISH: begin
                        // Completion only once the last dump byte has left
                        if (!rd_valid_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_LOAD_WAIT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign tx_start  = tx_start_q;
    assign tx_byte   = tx_byte_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mon_host.sv
// ============================================================================
//  Module   : tb_mon_host
//  Purpose  : Directed self-checking bench for mon_host with an echoing
//             UART model that can corrupt, go silent or inject dump bytes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mon_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = 16'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_data = 8'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [7:0]  rd_data;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy = 1'b0;
    logic        rx_strobe = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    mon_host #(.TIMEOUT(24'd100)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy),
        .rx_strobe(rx_strobe), .rx_data(rx_data)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model / monitor state (written only by the model block below)
    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    int cyc = 0, done_cnt = 0, err_cnt = 0, rx_cnt = 0;
    int rx_cyc = 0, err_cyc = 0, err_rx = 0;
    logic [1:0] last_code = 2'd0;
    bit   pend = 0;
    int   dly = 0, gap = 0, dump_taken = 0;
    logic [7:0] pend_byte = 8'd0;

    // Model controls (written only by the stimulus block)
    bit   echo_on = 1;
    int   corrupt_at = -1;
    int   dump_after = 0;
    int   dump_end = 0;
    int   dump_n = 0;
    logic [7:0] dump_arr[4];

    // UART echo model and output monitor, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            last_code = err_code;
            err_cyc = cyc;
            err_rx = rx_cnt;
        end
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        rx_strobe = 1'b0;
        if (tx_start) begin
            tx_log.push_back(tx_byte);
            pend = 1;
            dly = 3;
            tx_busy = 1'b1;
            pend_byte = tx_byte;
            if (tx_log.size() - 1 == corrupt_at) pend_byte = pend_byte ^ 8'h01;
        end else if (pend) begin
            if (dly == 0) begin
                pend = 0;
                tx_busy = 1'b0;
                if (echo_on) begin
                    rx_strobe = 1'b1;
                    rx_data = pend_byte;
                    rx_cnt++;
                    rx_cyc = cyc;
                end
            end else begin
                dly--;
            end
        end else if (dump_taken < dump_end && tx_log.size() >= dump_after) begin
            if (gap == 0) begin
                rx_strobe = 1'b1;
                rx_data = dump_arr[dump_n - (dump_end - dump_taken)];
                dump_taken++;
                rx_cnt++;
                rx_cyc = cyc;
                gap = 5;
            end else begin
                gap--;
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] len);
        int n = 0;
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] b);
        int n = 0;
        wr_data = b; wr_valid = 1'b1;
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) check("wr_accept", 32'd0, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Wait until done or err count moves past the given snapshot
    task automatic wait_end(input int d0, input int e0, input int budget);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0 && err_cnt == e0) check("end_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int b, d0, e0, r0, n;
        logic [7:0] exp8[8];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- load op=1 addr=0x0010 len=2 ----------------
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        exp8 = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'h55};
        send_cmd(2'd1, 16'h0010, 16'd2);
        push_wr(8'hAA);
        push_wr(8'h55);
        wait_end(d0, e0, 1000);
        check("load_tx_count", tx_log.size() - b, 8);
        for (int i = 0; i < 8; i++)
            if (b + i < tx_log.size()) check($sformatf("load_tx%0d", i), tx_log[b + i], exp8[i]);
        check("load_done", done_cnt - d0, 1);
        check("load_err", err_cnt - e0, 0);

        // ---------------- dump op=2 addr=0 len=3 ----------------
        @(negedge clk);
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt; r0 = rd_log.size();
        dump_arr = '{8'h11, 8'h22, 8'h33, 8'h00};
        dump_n = 3; dump_after = b + 6; dump_end = dump_taken + 3;
        rd_ready = 1'b1;
        send_cmd(2'd2, 16'h0000, 16'd3);
        wait_end(d0, e0, 1000);
        check("dump_rd_count", rd_log.size() - r0, 3);
        if (rd_log.size() >= r0 + 3) begin
            check("dump_rd0", rd_log[r0], 8'h11);
            check("dump_rd1", rd_log[r0 + 1], 8'h22);
            check("dump_rd2", rd_log[r0 + 2], 8'h33);
        end
        check("dump_done", done_cnt - d0, 1);
        check("dump_rd_valid_at_done", rd_valid, 0);

        // ---------------- header echo byte 2 corrupted ----------------
        @(negedge clk);
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        corrupt_at = b + 2;
        send_cmd(2'd1, 16'h0010, 16'd1);
        wait_end(d0, e0, 1000);
        repeat (30) @(negedge clk);
        corrupt_at = -1;
        check("echo_err", err_cnt - e0, 1);
        check("echo_err_code", last_code, 1);
        check("echo_tx_count", tx_log.size() - b, 3);
        check("echo_no_done", done_cnt - d0, 0);

        // ---------------- timeout: dump len=2, model silent ----------------
        @(negedge clk);
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        dump_n = 0; dump_after = b + 6; dump_end = dump_taken;
        send_cmd(2'd2, 16'h0100, 16'd2);
        wait_end(d0, e0, 1000);
        check("tmo_err_code", last_code, 2);
        check("tmo_latency_ok", (err_cyc - rx_cyc >= 98 && err_cyc - rx_cyc <= 106), 1);
        check("tmo_no_done", done_cnt - d0, 0);

        // ---------------- overrun: rd_ready held low ----------------
        @(negedge clk);
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt; r0 = rx_cnt;
        rd_ready = 1'b0;
        dump_arr = '{8'hA1, 8'hB2, 8'h00, 8'h00};
        dump_n = 2; dump_after = b + 6; dump_end = dump_taken + 2;
        send_cmd(2'd2, 16'h0000, 16'd2);
        wait_end(d0, e0, 1000);
        check("ovr_err_code", last_code, 3);
        check("ovr_on_second_rx", err_rx - r0, 8);
        check("ovr_rd_valid_dropped", rd_valid, 0);
        rd_ready = 1'b1;

        // ---------------- reset during LOAD_ECHO ----------------
        repeat (5) @(negedge clk);
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(2'd1, 16'h0200, 16'd2);
        push_wr(8'h3C);
        n = 0;
        while (tx_log.size() < b + 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_load", tx_log.size() - b, 7);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_err", err_cnt - e0, 0);

        // ---------------- exec op=3: header only, then done ----------------
        b = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        exp8 = '{8'h03, 8'h00, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h00};
        send_cmd(2'd3, 16'hBEEF, 16'h1234);
        wait_end(d0, e0, 1000);
        check("exec_tx_count", tx_log.size() - b, 6);
        for (int i = 0; i < 6; i++)
            if (b + i < tx_log.size()) check($sformatf("exec_tx%0d", i), tx_log[b + i], exp8[i]);
        check("exec_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mon_host.md
MON_HOST -- requirements
Module: mon_host

Interface
REQ-001 Parameter TIMEOUT, default 24'd1200000, is the echo/data wait limit in clk cycles (100 ms at 12 MHz).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both high.
REQ-005 cmd_op  in  2  1=load, 2=dump, 3=exec, 0=flush-only.
REQ-006 cmd_addr  in  16  target address; cmd_len  in  16  byte count (exec: word stored at 0/1).
REQ-007 wr_valid/wr_ready/wr_data  in/out/in  1/1/8  load payload stream.
REQ-008 rd_valid/rd_ready/rd_data  out/in/out  1/1/8  dump data stream.
REQ-009 busy  out  1  high from command acceptance until done or err.
REQ-010 done  out  1  one-cycle pulse on successful command completion.
REQ-011 err/err_code  out/out  1/2  one-cycle pulse; code 1=echo mismatch, 2=timeout, 3=rd overrun.
REQ-012 tx_start/tx_byte  out/out  1/8  UART transmit strobe and byte.
REQ-013 tx_busy  in  1  UART transmitter active.
REQ-014 rx_strobe/rx_data  in/in  1/8  UART received-byte pulse and byte.

Function
REQ-015 Block SHALL be the host-side initiator of the monitor serial protocol: 6-byte header {op, 0x00, addr[15:8], addr[7:0], len[15:8], len[7:0]}, then payload.
REQ-016 States SHALL be IDLE, HDR_TX, HDR_ECHO, LOAD_WAIT, LOAD_TX, LOAD_ECHO, DUMP_RX, FINISH.
REQ-017 cmd_ready SHALL equal (state==IDLE); acceptance latches op/addr/len, sets header index 0, enters HDR_TX.
REQ-018 Transmission SHALL be stop-and-wait: tx_start pulses one cycle only when tx_busy low; next byte only after its echo is received.
REQ-019 HDR_TX -> HDR_ECHO after tx_start; HDR_ECHO on rx_strobe compares rx_data to sent byte; mismatch -> err code 1.
REQ-020 After echo of header byte 5: op=1 and len!=0 -> LOAD_WAIT; op=2 and len!=0 -> DUMP_RX; otherwise FINISH.
REQ-021 LOAD_WAIT SHALL assert wr_ready; on wr_valid&wr_ready latch byte, go LOAD_TX; LOAD_TX/LOAD_ECHO as header; each good echo decrements len, len==0 -> FINISH.
REQ-022 DUMP_RX SHALL capture each rx_data into a one-byte holding register, set rd_valid, decrement len; len==0 after capture -> FINISH.
REQ-023 rd_valid SHALL clear on rd_valid&rd_ready; rx_strobe while rd_valid high and not simultaneously consumed -> err code 3.
REQ-024 FINISH SHALL wait for rd_valid low, pulse done, return to IDLE.
REQ-025 Timeout counter SHALL reload to TIMEOUT on entering HDR_ECHO, LOAD_ECHO, DUMP_RX and on every rx_strobe, count down only in those states, and reaching 0 -> err code 2.
REQ-026 rx_strobe in HDR_TX or LOAD_TX SHALL raise err code 1; rx_strobe in IDLE, LOAD_WAIT, FINISH SHALL be ignored.
REQ-027 Any error SHALL pulse err one cycle, drop rd_valid, return to IDLE without done.
REQ-028 len counter SHALL be 16 bits; len=16'hFFFF SHALL complete without wrap.

Reset
REQ-029 On rst: state IDLE; tx_start, done, err, rd_valid, wr_ready, busy 0; err_code 0; tx_byte 0; counters 0.
REQ-030 rst mid-command SHALL abandon it silently (no done/err pulse).

Structure
REQ-031 Package mon_pkg SHALL hold op codes, err codes, state encoding, header length 6, default TIMEOUT.
REQ-032 No sub-module; mon_host SHALL connect directly beside the existing uart instance.

Verification
REQ-033 Load op=1 addr=0x0010 len=2 data 0xAA,0x55 with echoing model -> 8 tx bytes 01 00 00 10 00 02 AA 55, one done.
REQ-034 Dump op=2 addr=0x0000 len=3, model returns 11 22 33 -> rd stream 11,22,33, done after third byte consumed.
REQ-035 Load header echo byte 2 corrupted (0x01 instead of 0x00) -> err, err_code=1, no further tx_start.
REQ-036 Dump len=2, model silent after header, TIMEOUT=100 -> err code 2 ~100 cycles after last echo.
REQ-037 Dump len=2, rd_ready held 0, two bytes arrive -> err code 3 on second rx_strobe.
REQ-038 rst asserted during LOAD_ECHO -> IDLE, cmd_ready=1 next cycle, no done/err.
